// File: rtl/bin2bcd_stream_pkg.sv
// bcd_pkg: shared state encoding, digit width and the digit-count sizing helper for bin2bcd_stream.
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  // Decimal digits needed for the largest magnitude an input can carry.
  function automatic int min_digits(int bin_w, bit is_signed);
    longint unsigned v;
    int d;
    v = is_signed ? (64'd1 << (bin_w - 1)) : ((64'd1 << bin_w) - 64'd1);
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bin2bcd_stream_if.sv
// bin2bcd_stream_if: operand/result handshake bundle; out_neg exists only with BIN2BCD_SIGN_EN.
interface bin2bcd_stream_if import bcd_pkg::*; #(parameter int BIN_W = 8, parameter int DIGITS = 3);
  logic [BIN_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd;
  logic out_valid;
  logic out_ready;
`ifdef BIN2BCD_SIGN_EN
  logic out_neg;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_bcd, out_valid, out_neg);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_bcd, out_valid, out_neg);
`else
  modport master (output in_data, in_valid, out_ready, input in_ready, out_bcd, out_valid);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_bcd, out_valid);
`endif
endinterface

// File: rtl/bin2bcd_stream_add3.sv
// bcd_add3: single-digit double-dabble correction, adds 3 to any digit of 5 or more.
module bcd_add3 import bcd_pkg::*; (
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);
  always_comb d_out = d_in >= 4'd5 ? d_in + 4'd3 : d_in;
endmodule

// File: rtl/bin2bcd_stream.sv
// bin2bcd_stream: handshaked serial double-dabble converter, one bit per clock.
// Define BIN2BCD_SIGN_EN for two's complement input with a registered out_neg sign.
module bin2bcd_stream import bcd_pkg::*; #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst,
  bin2bcd_stream_if.slave io
);
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
`ifdef BIN2BCD_SIGN_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif
  if (BIN_W < 2 || BIN_W > 32 || DIGITS < min_digits(BIN_W, SIGN_EN)) begin : g_bad_cfg
    $error("bin2bcd_stream: DIGITS too small for BIN_W or BIN_W out of range");
  end
  state_t state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d, mag;
  logic [ACC_W-1:0] acc_q, acc_d, adj, bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, accept, last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_add3 u_add3 (.d_in(acc_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]), .d_out(adj[BCD_DIGIT_W*i +: BCD_DIGIT_W]));
  end
  assign io.in_ready  = (state_q == IDLE) | ((state_q == DONE) & io.out_ready);
  assign io.out_bcd   = bcd_q;
  assign io.out_valid = valid_q;
  assign accept = io.in_valid & io.in_ready;
  assign last   = (state_q == CONV) && (cnt_q == CNT_W'(1));
`ifdef BIN2BCD_SIGN_EN
  logic sgn_q, sgn_d, neg_q, neg_d;
  // -(-2^(BIN_W-1)) wraps to the same bit pattern, which reads correctly as unsigned.
  assign mag = io.in_data[BIN_W-1] ? -io.in_data : io.in_data;
  assign io.out_neg = neg_q;
  always_comb begin
    sgn_d = accept ? io.in_data[BIN_W-1] : sgn_q;
    neg_d = last ? sgn_q : neg_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
      neg_q <= neg_d;
    end
  end
`else
  assign mag = io.in_data;
`endif
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    if (state_q == CONV) begin
      acc_d   = ACC_W'({adj, sr_q[BIN_W-1]});
      sr_d    = sr_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = last ? DONE : CONV;
      valid_d = last;
      bcd_d   = last ? ACC_W'({adj, sr_q[BIN_W-1]}) : bcd_q;
    end else if (accept) begin
      sr_d    = mag;
      acc_d   = '0;
      cnt_d   = CNT_W'(BIN_W);
      state_d = CONV;
      valid_d = 1'b0;
    end else if (state_q == DONE && io.out_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: doc/bin2bcd_stream.md
# bin2bcd_stream

Parametrised, handshaked serial binary-to-BCD converter. It accepts a parallel `BIN_W`-bit word on a valid/ready input and runs shift-add-3 (double dabble) one bit per clock. It then presents a `DIGITS`-digit packed BCD result on a valid/ready output. It replaces the fixed 6-bit serial-fed converter plus its separate input serialiser in display/readout datapaths, and supports back-to-back conversions.

## Interface
Parameters:
- `BIN_W`, 8, binary input width (2..32).
- `DIGITS`, 3, BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W − 1; violation is an elaboration-time error.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  BIN_W  binary operand.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  converter can accept.
- `out_bcd`  out  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
- `out_neg`  out  1  result sign. Present only with `BIN2BCD_SIGN_EN`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.

## Operation
- FSM states:
  - IDLE: no operand held.
  - CONV: shifting.
  - DONE: result held.
- IDLE: `in_ready`=1. On `in_valid`:
  - Latch `in_data` into the shift register.
  - Clear the BCD accumulator.
  - Load bit counter = BIN_W.
  - Go to CONV.
- CONV, each cycle:
  - Every BCD digit ≥5 gets +3.
  - The accumulator and shift register shift left as one, with the shift-register MSB entering accumulator bit 0.
  - Counter decrements.
  - When the counter reaches 1, this is the last shift; the next state is DONE.
- DONE: `out_valid`=1; `out_bcd` is stable and held until the handshake.
  - `out_valid & out_ready` with no `in_valid`: go to IDLE.
  - `out_valid & out_ready` with `in_valid`: accept the new operand in the same cycle and go to CONV.
- `in_ready` = IDLE | (DONE & `out_ready`). This is a combinational path from `out_ready`; it is documented and intended.
- `in_valid` is ignored in CONV, and in DONE without `out_ready`. `out_ready` is ignored outside DONE.
- Arithmetic:
  - Add-3 is applied per 4-bit digit, before the shift, in the same cycle.
  - Accumulator width is 4*DIGITS.
  - Bits shifted out of the top digit are discarded; the DIGITS rule guarantees none are nonzero.
- Reset (asserted at any time, including mid-CONV):
  - State → IDLE.
  - `out_bcd`=0, `out_valid`=0, `out_neg`=0, counter=0.
  - Any in-flight operand is lost.
  - `in_ready` is 1 once reset is released.

## Timing
- Handshake edge = the rising edge where `in_valid & in_ready`.
- `out_valid` rises BIN_W clock edges after the handshake edge.
- Sustained throughput with `out_ready` tied high: one result per BIN_W+1 cycles.
- `out_bcd` changes only on the CONV→DONE edge or on reset.
- All outputs are registered except `in_ready`.

## Configuration
- Macro `BIN2BCD_SIGN_EN`.
- Defined:
  - `in_data` is two's complement.
  - On accept, the magnitude is latched: −x for a negative input, with −2^(BIN_W−1) → 2^(BIN_W−1), which is representable unsigned.
  - The sign is registered into `out_neg` at the same edge `out_valid` rises.
  - The DIGITS check uses 2^(BIN_W−1).
- Undefined:
  - `in_data` is unsigned.
  - The `out_neg` port does not exist.

## Structure
- Shared package `bcd_pkg`:
  - State enum (IDLE/CONV/DONE).
  - `BCD_DIGIT_W`=4 constant.
  - Function `min_digits(bin_w, signed)` used for the elaboration check.
- Sub-module `bcd_add3`: combinational single-digit cell, out = in ≥5 ? in+3 : in. It is instantiated DIGITS times via generate.

## Test plan
- BIN_W=8, DIGITS=3, `in_data`=255, `out_ready`=1 → `out_valid` 8 edges after the handshake, `out_bcd`=0x255.
- `in_data`=0 → `out_bcd`=0x000; `in_data`=25 → 0x025.
- Back-to-back 99 then 100, with `in_valid` held and `out_ready`=1 → 0x099 then 0x100; `out_valid` pulses 9 cycles apart; `in_ready` high in DONE.
- `out_ready` low for 5 cycles in DONE → `out_valid` and `out_bcd` stable; `in_ready`=0; the new operand is held off until the handshake.
- Reset asserted at CONV cycle 4 → all outputs 0 immediately, `in_ready`=1 after release; the next conversion of 7 gives 0x007.
- `BIN2BCD_SIGN_EN`, BIN_W=8:
  - 0x80 → `out_neg`=1, 0x128.
  - 0xFF → `out_neg`=1, 0x001.
  - 0x7F → `out_neg`=0, 0x127.
